game_tick_gen: RTL and testbench

Multi-channel clock-enable generator that replaces the fixed power-of-two clock dividers feeding game logic, BCD conversion and food-map flushing. All consumers stay on the single pixel-domain clock and qualify their logic with a one-cycle `tick[i]`. Each channel has a runtime-programmable period and can be free-running or frame-synchronous (counting VGA vsync edges). Global pause, single-step and resync support debugging of the game.

---
 rtl/game_tick_gen_if.sv | 21 ++
 rtl/game_tick_gen.sv | 96 +++++++++
 tb/tb_game_tick_gen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_tick_gen_if.sv
// game_tick_gen_if: period configuration bus
// for the tick generator channels.
interface game_tick_gen_if #(
  parameter int CNT_W = 24
);
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_period;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_period
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_period
  );
endinterface

// File: rtl/game_tick_gen.sv
// game_tick_gen: multi-channel clock-enable generator
// with free-run / frame-sync channels, pause, step, resync.
module game_tick_gen #(
  parameter int               NUM_CH           = 4,
  parameter int               CNT_W            = 24,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD   = CNT_W'(1048576),
  parameter bit               VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              resync,
  input  logic              vsync_in,
  input  logic [NUM_CH-1:0] sync_mask,
  game_tick_gen_if.slave    cfg,
  output logic [NUM_CH-1:0] tick,
  output logic              frame_edge
);

  localparam logic ACT = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

  logic             vs_d;
  logic             vs_edge;
  logic [CNT_W-1:0] period [NUM_CH];
  logic [CNT_W-1:0] cnt    [NUM_CH];
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] adv;

  assign vs_edge = (vsync_in == ACT) && (vs_d != ACT);

  // Terminal count, config hit and advance qualifier per channel;
  // a stored period of 0 terminates at count 0 just like period 1.
  always_comb begin
    term = '0;
    hit  = '0;
    adv  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (period[i] == '0)
        term[i] = (cnt[i] == '0);
      else
        term[i] = (cnt[i] == period[i] - 1'b1);
      hit[i] = cfg.cfg_we && (cfg.cfg_ch == 3'(i));
      adv[i] = run && (!sync_mask[i] || vs_edge);
    end
  end

  // Vsync edge detector and registered frame pulse, free of run.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d       <= ~ACT;
      frame_edge <= 1'b0;
    end else begin
      vs_d       <= vsync_in;
      frame_edge <= vs_edge;
    end
  end

  // Period registers: written by an in-range config strobe.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst)
        period[i] <= DEFAULT_PERIOD;
      else if (hit[i])
        period[i] <= cfg.cfg_period;
    end
  end

  // Channel counters and ticks: resync > write > step > count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        cnt[i]  <= '0;
        tick[i] <= 1'b0;
      end else if (resync || hit[i]) begin
        cnt[i]  <= '0;
        tick[i] <= 1'b0;
      end else if (!run && step) begin
        cnt[i]  <= '0;
        tick[i] <= 1'b1;
      end else if (adv[i]) begin
        if (term[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
        end else begin
          cnt[i]  <= cnt[i] + 1'b1;
          tick[i] <= 1'b0;
        end
      end else begin
        tick[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: directed vectors with hand-computed
// expectations for the tick generator.
module tb_game_tick_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       step;
  logic       resync;
  logic       vsync_in;
  logic [3:0] sync_mask;
  logic [3:0] tick;
  logic       frame_edge;

  int n_vec = 0;
  int n_bad = 0;

  game_tick_gen_if #(.CNT_W(24)) cfg_bus ();

  game_tick_gen dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .resync     (resync),
    .vsync_in   (vsync_in),
    .sync_mask  (sync_mask),
    .cfg        (cfg_bus.slave),
    .tick       (tick),
    .frame_edge (frame_edge)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] ch, input logic [23:0] per);
    cfg_bus.cfg_we     = 1'b1;
    cfg_bus.cfg_ch     = ch;
    cfg_bus.cfg_period = per;
    cyc(1);
    cfg_bus.cfg_we     = 1'b0;
  endtask

  initial begin
    logic       acc;
    logic       acc2;
    rst       = 1'b1;
    run       = 1'b0;
    step      = 1'b0;
    resync    = 1'b0;
    vsync_in  = 1'b1;
    sync_mask = 4'b0000;
    cfg_bus.cfg_we     = 1'b0;
    cfg_bus.cfg_ch     = 3'd0;
    cfg_bus.cfg_period = 24'd0;
    cyc(2);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_fe", 32'(frame_edge), 32'h0);

    // free-run, ch0 period 4
    rst = 1'b0;
    run = 1'b1;
    wr(3'd0, 24'd4);
    chk("fr_wr", 32'(tick[0]), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk($sformatf("fr_k%0d", k), 32'(tick[0]), 32'((k % 4) == 0));
    end
    acc = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      cyc(1);
      acc = acc | tick[1];
    end
    chk("fr_ch1_quiet", 32'(acc), 32'h0);

    // period 0 and 1 both tick every cycle
    wr(3'd2, 24'd0);
    chk("p0_wr", 32'(tick[2]), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk($sformatf("p0_k%0d", k), 32'(tick[2]), 32'h1);
    end
    wr(3'd2, 24'd1);
    chk("p1_wr", 32'(tick[2]), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk($sformatf("p1_k%0d", k), 32'(tick[2]), 32'h1);
    end
    wr(3'd2, 24'hFFFFFF);

    // frame-sync ch1 period 3
    sync_mask = 4'b0010;
    wr(3'd1, 24'd3);
    acc  = 1'b0;
    acc2 = 1'b0;
    for (int f = 1; f <= 9; f++) begin
      repeat (95) begin
        cyc(1);
        acc  = acc | frame_edge;
        acc2 = acc2 | tick[1];
      end
      vsync_in = 1'b0;
      cyc(1);
      chk($sformatf("fs_fe%0d", f), 32'(frame_edge), 32'h1);
      chk($sformatf("fs_t%0d", f), 32'(tick[1]), 32'((f % 3) == 0));
      repeat (4) begin
        cyc(1);
        acc  = acc | frame_edge;
        acc2 = acc2 | tick[1];
      end
      vsync_in = 1'b1;
    end
    chk("fs_fe_quiet", 32'(acc), 32'h0);
    chk("fs_t_quiet", 32'(acc2), 32'h0);
    sync_mask = 4'b0000;
    wr(3'd1, 24'hFFFFFF);

    // pause holds counters, step fires all channels
    wr(3'd0, 24'd5);
    cyc(3);
    run = 1'b0;
    acc = 1'b0;
    repeat (20) begin
      cyc(1);
      acc = acc | (|tick);
    end
    chk("pause_quiet", 32'(acc), 32'h0);
    run = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      cyc(1);
      chk($sformatf("resume_k%0d", k), 32'(tick[0]), 32'(k == 2));
    end
    run = 1'b0;
    cyc(1);
    chk("pause_tick", 32'(tick), 32'h0);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    chk("step_all", 32'(tick), 32'hF);
    run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step = (k == 2);
      cyc(1);
      chk($sformatf("post_step_k%0d", k), 32'(tick), 32'(k == 5));
    end
    step = 1'b0;

    // config write on the terminal count wins
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk($sformatf("pre_col_k%0d", k), 32'(tick[0]), 32'h0);
    end
    wr(3'd0, 24'd5);
    chk("col_wr", 32'(tick[0]), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      chk($sformatf("col_k%0d", k), 32'(tick[0]), 32'(k == 5));
    end

    // resync beats step; resync restarts counting
    run    = 1'b0;
    resync = 1'b1;
    step   = 1'b1;
    cyc(1);
    chk("rs_step", 32'(tick), 32'h0);
    step   = 1'b0;
    resync = 1'b0;
    run    = 1'b1;
    cyc(2);
    resync = 1'b1;
    cyc(1);
    resync = 1'b0;
    chk("rs_run", 32'(tick[0]), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      chk($sformatf("rs_k%0d", k), 32'(tick[0]), 32'(k == 5));
    end

    // out-of-range channel write is ignored
    wr(3'd6, 24'd1);
    chk("oor_k1", 32'(tick), 32'h0);
    for (int k = 2; k <= 5; k++) begin
      cyc(1);
      chk($sformatf("oor_k%0d", k), 32'(tick), 32'(k == 5));
    end

    // reset just before a tick discards it and restores periods
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mr_tick", 32'(tick), 32'h0);
    acc = 1'b0;
    repeat (12) begin
      cyc(1);
      acc = acc | (|tick);
    end
    chk("mr_default", 32'(acc), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
